// File: rtl/vga_text_ctrl.sv
// 80x30 text-mode VGA controller: 640x480@60 timing from a 50 MHz clock, character
// fetch from video RAM, glyph fetch from font ROM, blinking block cursor overlay.
module vga_text_ctrl #(
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h00F,
  parameter int          BLINK_FRAMES = 32,
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  output logic [11:0] vram_addr,
  input  logic [7:0]  vga_q,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_q,
  input  logic [11:0] cur_addr,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Sync flags travel the pipeline as active-high so an all-zero reset state
  // never produces a spurious sync pulse.
  typedef struct packed {
    logic [11:0] caddr;
    logic [3:0]  vrow;
    logic [2:0]  hbit;
    logic        act;
    logic        hsync;
    logic        vsync;
  } s0_t;

  typedef struct packed {
    logic [2:0] hbit;
    logic       act;
    logic       hit;
    logic       hsync;
    logic       vsync;
  } s1_t;

  logic          pix_en;
  logic [9:0]    h_cnt, v_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          active;
  logic [11:0]   char_addr;
  logic          pixel;
  logic [11:0]   rgb;
  s0_t           s0;
  s1_t           s1;

  assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign char_addr   = {6'd0, v_cnt[9:4]} * 12'd80 + {5'd0, h_cnt[9:3]};
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
  assign pixel       = font_q[3'd7 - s1.hbit] ^ s1.hit;
  assign {vga_r, vga_g, vga_b} = rgb;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // S0 addresses video RAM, S1 addresses the font ROM, the output register
  // samples the returned glyph row; each memory has one pixel tick to answer.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      vram_addr   <= '0;
      font_addr   <= '0;
      s0          <= '0;
      s1          <= '0;
      rgb         <= '0;
      vga_blank_n <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
    end else if (pix_en) begin
      if (active) vram_addr <= char_addr;
      s0.caddr <= char_addr;
      s0.vrow  <= v_cnt[3:0];
      s0.hbit  <= h_cnt[2:0];
      s0.act   <= active;
      s0.hsync <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      s0.vsync <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);

      font_addr <= {vga_q, s0.vrow};
      s1.hit    <= (s0.caddr == cur_addr) && blink_phase;
      s1.hbit   <= s0.hbit;
      s1.act    <= s0.act;
      s1.hsync  <= s0.hsync;
      s1.vsync  <= s0.vsync;

      rgb         <= s1.act ? (pixel ? FG_COLOR : BG_COLOR) : 12'h000;
      vga_blank_n <= s1.act;
      vga_hs      <= ~s1.hsync;
      vga_vs      <= ~s1.vsync;
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl on a shrunken raster (48x46 ticks) so that
// several whole frames fit in a short run; character layout stays 80 per row.
module tb_vga_text_ctrl;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;  // 48
  localparam int VA = 40, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;  // 46
  localparam int NF = HT * VT;                                              // ticks per frame
  localparam logic [11:0] FG = 12'hFFF, BG = 12'h00F;

  logic        CLOCK_50 = 1'b1;
  logic        rst = 1'b1;
  logic [11:0] vram_addr, font_addr;
  logic [7:0]  vga_q = 8'h00, font_q = 8'h00;
  logic [11:0] cur_addr = 12'd2400;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [7:0]  font_pat = 8'h80;

  int checks = 0;
  int passed = 0;
  int edges  = 0;

  vga_text_ctrl #(
    .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_FRAMES(3),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .vram_addr(vram_addr), .vga_q(vga_q),
    .font_addr(font_addr), .font_q(font_q),
    .cur_addr(cur_addr),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous-read memory models.
  always @(posedge CLOCK_50) begin
    vga_q  <= (vram_addr == 12'd162) ? 8'h41 : 8'h20;
    font_q <= font_pat;
  end

  always @(posedge CLOCK_50) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  // Clock edge (counted from reset release) after which pixel (h,v) of frame f is on the pins.
  function automatic int pix(input int f, input int h, input int v);
    return 2 * (f * NF + v * HT + h) + 6;
  endfunction

  task automatic wait_edge(input int k);
    int guard = 0;
    while (edges < k && guard < 30000) begin
      @(negedge CLOCK_50);
      guard++;
    end
    if (edges != k) begin
      checks++;
      $display("FAIL wait_edge: reached edge %0d, wanted %0d", edges, k);
    end
  endtask

  task automatic apply_reset;
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #100;
    checks++; if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start} !== {3'b110, 12'h000, 1'b0})
      $display("FAIL reset_pins: got %b", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start}); else passed++;
    checks++; if (vram_addr !== 12'd0) $display("FAIL reset_vram: got %h want 000", vram_addr); else passed++;
    checks++; if (font_addr !== 12'd0) $display("FAIL reset_font: got %h want 000", font_addr); else passed++;
    #95 rst = 1'b0;
    wait_edge(1);
    checks++; if (frame_start !== 1'b1) $display("FAIL fs_first: got %b want 1", frame_start); else passed++;
    wait_edge(2);
    checks++; if (frame_start !== 1'b0) $display("FAIL fs_width: got %b want 0", frame_start); else passed++;
  endtask

  task automatic test_timing;
    int hs_f[$], hs_r[$], vs_f[$], vs_r[$], fs[$];
    logic hs_p, vs_p;
    int guard = 0;
    hs_p = vga_hs;
    vs_p = vga_vs;
    while (edges < 4 * NF + 6 && guard < 20000) begin
      @(negedge CLOCK_50);
      guard++;
      if (hs_p && !vga_hs) hs_f.push_back(edges);
      if (!hs_p && vga_hs) hs_r.push_back(edges);
      if (vs_p && !vga_vs) vs_f.push_back(edges);
      if (!vs_p && vga_vs) vs_r.push_back(edges);
      if (frame_start) fs.push_back(edges);
      hs_p = vga_hs;
      vs_p = vga_vs;
    end
    checks++; if (hs_f.size() < 1 || hs_f[0] != pix(0, HA + HF, 0))
      $display("FAIL hs_first_fall: got %0d want %0d", hs_f.size() ? hs_f[0] : -1, pix(0, HA + HF, 0)); else passed++;
    checks++; if (hs_f.size() < 2 || hs_f[1] - hs_f[0] != 2 * HT)
      $display("FAIL hs_period: got %0d want %0d", hs_f.size() > 1 ? hs_f[1] - hs_f[0] : -1, 2 * HT); else passed++;
    checks++; if (hs_r.size() < 1 || hs_f.size() < 1 || hs_r[0] - hs_f[0] != 2 * HS)
      $display("FAIL hs_low: got %0d want %0d", (hs_r.size() && hs_f.size()) ? hs_r[0] - hs_f[0] : -1, 2 * HS); else passed++;
    checks++; if (vs_f.size() < 1 || vs_f[0] != pix(0, 0, VA + VF))
      $display("FAIL vs_first_fall: got %0d want %0d", vs_f.size() ? vs_f[0] : -1, pix(0, 0, VA + VF)); else passed++;
    checks++; if (vs_f.size() < 2 || vs_f[1] - vs_f[0] != 2 * NF)
      $display("FAIL vs_period: got %0d want %0d", vs_f.size() > 1 ? vs_f[1] - vs_f[0] : -1, 2 * NF); else passed++;
    checks++; if (vs_r.size() < 1 || vs_f.size() < 1 || vs_r[0] - vs_f[0] != 2 * VS * HT)
      $display("FAIL vs_low: got %0d want %0d", (vs_r.size() && vs_f.size()) ? vs_r[0] - vs_f[0] : -1, 2 * VS * HT); else passed++;
    checks++; if (fs.size() != 2)
      $display("FAIL fs_count: got %0d want 2", fs.size()); else passed++;
    checks++; if (fs.size() < 2 || fs[0] != 2 * NF + 1 || fs[1] - fs[0] != 2 * NF)
      $display("FAIL fs_period: got first %0d want %0d", fs.size() ? fs[0] : -1, 2 * NF + 1); else passed++;
  endtask

  task automatic test_addressing;
    font_pat = 8'h80;
    cur_addr = 12'd2400;
    apply_reset;
    wait_edge(2 * (35 * HT + 16) + 2);
    checks++; if (vram_addr !== 12'd162) $display("FAIL vram_h16: got %0d want 162", vram_addr); else passed++;
    checks++; if (font_addr !== 12'h203) $display("FAIL font_h15: got %h want 203", font_addr); else passed++;
    wait_edge(2 * (35 * HT + 17) + 2);
    checks++; if (vram_addr !== 12'd162) $display("FAIL vram_h17: got %0d want 162", vram_addr); else passed++;
    checks++; if (font_addr !== 12'h413) $display("FAIL font_h16: got %h want 413", font_addr); else passed++;
  endtask

  task automatic test_pixel;
    font_pat = 8'h80;
    cur_addr = 12'd2400;
    apply_reset;
    wait_edge(5);
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== 13'h0) $display("FAIL pix_pre: got %h want 0", {vga_blank_n, vga_r, vga_g, vga_b}); else passed++;
    wait_edge(pix(0, 0, 0));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, FG}) $display("FAIL pix_0_0: got %h want %h", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, FG}); else passed++;
    wait_edge(pix(0, 1, 0));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, BG}) $display("FAIL pix_1_0: got %h want %h", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, BG}); else passed++;
    wait_edge(pix(0, 7, 0));
    checks++; if ({vga_r, vga_g, vga_b} !== BG) $display("FAIL pix_7_0: got %h want %h", {vga_r, vga_g, vga_b}, BG); else passed++;
    wait_edge(pix(0, 8, 0));
    checks++; if ({vga_r, vga_g, vga_b} !== FG) $display("FAIL pix_8_0: got %h want %h", {vga_r, vga_g, vga_b}, FG); else passed++;
    wait_edge(pix(0, 16, 35));
    checks++; if ({vga_r, vga_g, vga_b} !== FG) $display("FAIL pix_16_35: got %h want %h", {vga_r, vga_g, vga_b}, FG); else passed++;
  endtask

  task automatic test_blanking;
    font_pat = 8'hFF;
    cur_addr = 12'd2400;
    apply_reset;
    wait_edge(pix(0, HA, 10));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== 13'h0) $display("FAIL hblank_first: got %h want 0", {vga_blank_n, vga_r, vga_g, vga_b}); else passed++;
    wait_edge(pix(0, HT - 1, 10));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== 13'h0) $display("FAIL hblank_last: got %h want 0", {vga_blank_n, vga_r, vga_g, vga_b}); else passed++;
    wait_edge(pix(0, HA - 1, VA - 1));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, FG}) $display("FAIL last_active: got %h want %h", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, FG}); else passed++;
    wait_edge(pix(0, HA, VA - 1));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== 13'h0) $display("FAIL after_last: got %h want 0", {vga_blank_n, vga_r, vga_g, vga_b}); else passed++;
    wait_edge(pix(0, 0, VA));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== 13'h0) $display("FAIL vblank: got %h want 0", {vga_blank_n, vga_r, vga_g, vga_b}); else passed++;
  endtask

  // BLINK_FRAMES=3: phase is 0 in frames 0-1, 1 in frames 2-4, 0 again in frame 5.
  task automatic test_cursor;
    logic [5:0]  show;
    logic [11:0] exp;
    show = 6'b001100;
    font_pat = 8'h00;
    cur_addr = 12'd0;
    apply_reset;
    for (int f = 0; f < 6; f++) begin
      cur_addr = (f == 4) ? 12'd2400 : 12'd0;
      exp = show[f] ? FG : BG;
      wait_edge(pix(f, 0, 0));
      checks++; if ({vga_r, vga_g, vga_b} !== exp) $display("FAIL cursor_f%0d: got %h want %h", f, {vga_r, vga_g, vga_b}, exp); else passed++;
      if (f == 2) begin
        wait_edge(pix(f, 8, 0));
        checks++; if ({vga_r, vga_g, vga_b} !== BG) $display("FAIL cursor_next_char: got %h want %h", {vga_r, vga_g, vga_b}, BG); else passed++;
        wait_edge(pix(f, 7, 15));
        checks++; if ({vga_r, vga_g, vga_b} !== FG) $display("FAIL cursor_corner: got %h want %h", {vga_r, vga_g, vga_b}, FG); else passed++;
        wait_edge(pix(f, 0, 16));
        checks++; if ({vga_r, vga_g, vga_b} !== BG) $display("FAIL cursor_below: got %h want %h", {vga_r, vga_g, vga_b}, BG); else passed++;
      end
    end
  endtask

  task automatic test_async_reset;
    font_pat = 8'h80;
    cur_addr = 12'd2400;
    apply_reset;
    wait_edge(pix(0, 16, 20));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, FG}) $display("FAIL pre_reset: got %h want %h", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, FG}); else passed++;
    #3 rst = 1'b1;
    #1;
    checks++; if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start} !== {3'b110, 12'h000, 1'b0})
      $display("FAIL async_pins: got %b", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start}); else passed++;
    checks++; if ({vram_addr, font_addr} !== 24'h0) $display("FAIL async_addr: got %h want 0", {vram_addr, font_addr}); else passed++;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst = 1'b0;
    wait_edge(1);
    checks++; if (frame_start !== 1'b1) $display("FAIL restart_fs: got %b want 1", frame_start); else passed++;
    wait_edge(pix(0, 0, 0));
    checks++; if ({vga_blank_n, vga_r, vga_g, vga_b} !== {1'b1, FG}) $display("FAIL restart_pix: got %h want %h", {vga_blank_n, vga_r, vga_g, vga_b}, {1'b1, FG}); else passed++;
  endtask

  initial begin
    test_reset;
    test_timing;
    test_addressing;
    test_pixel;
    test_blanking;
    test_cursor;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
